// File: rtl/axi_sram_controller.sv
// AXI4 subordinate in front of a single-port, byte-writable 32-bit word memory.
// Reads and writes share the port; a round-robin arbiter resolves simultaneous AW/AR.
module axi_sram_controller #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ID_W        = 4,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a source keeps valid and payload stable until that edge.
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t state_q, state_d;

  logic [31:0]     mem [DEPTH_WORDS];
  logic            fav_write_q;
  logic [ID_W-1:0] id_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]      len_q, cnt_q;
  logic [1:0]      burst_q;
  logic            werr_q, rd_done_q;
  logic            p_q, p_last_q;
  logic [31:0]     mem_q;
  logic            o_valid_q, o_last_q;
  logic [31:0]     o_data_q;
  logic [1:0]      o_resp_q;
  logic            s_valid_q, s_last_q;
  logic [31:0]     s_data_q;
  logic [1:0]      s_resp_q;

  logic            take_aw, take_ar, w_beat, w_final;
  logic            issue, issue_last, r_done, o_free;
  logic [1:0]      occ;
  logic [IDX_W-1:0] aw_idx, ar_idx, rd_idx;
  logic [31:0]     in_data;
  logic [1:0]      in_resp;
  logic            unused_addr_bits;

  assign aw_idx = awaddr[IDX_W+1:2];
  assign ar_idx = araddr[IDX_W+1:2];
  assign unused_addr_bits = ^{awaddr[31:IDX_W+2], awaddr[1:0], araddr[31:IDX_W+2], araddr[1:0]};

  always_comb begin
    take_aw    = (state_q == IDLE) && awvalid && (!arvalid || fav_write_q);
    take_ar    = (state_q == IDLE) && arvalid && !take_aw;
    w_beat     = (state_q == WDATA) && wvalid;
    w_final    = w_beat && (cnt_q == len_q);
    o_free     = !o_valid_q || rready;
    // Beats that will be resident next cycle; a new read is issued only if it has a home.
    occ        = {1'b0, o_valid_q} + {1'b0, s_valid_q} + {1'b0, p_q} - {1'b0, o_valid_q && rready};
    issue      = take_ar || ((state_q == RDATA) && !rd_done_q && (occ < 2'd2));
    issue_last = take_ar ? (arlen == 8'd0) : (cnt_q == len_q);
    rd_idx     = take_ar ? ar_idx : idx_q;
    r_done     = o_valid_q && rready && o_last_q;
    in_data    = burst_q[1] ? 32'd0 : mem_q;
    in_resp    = burst_q[1] ? 2'b10 : 2'b00;
  end

  assign awready = take_aw;
  assign arready = take_ar;
  assign wready  = (state_q == WDATA);
  assign bvalid  = (state_q == WRESP);
  assign bid     = id_q;
  assign bresp   = {werr_q, 1'b0};
  assign rid     = id_q;
  assign rvalid  = o_valid_q;
  assign rdata   = o_data_q;
  assign rresp   = o_resp_q;
  assign rlast   = o_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_aw)      state_d = WDATA;
        else if (take_ar) state_d = RDATA;
      end
      WDATA:   if (w_final) state_d = WRESP;
      WRESP:   if (bready)  state_d = IDLE;
      RDATA:   if (r_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fav_write_q <= 1'b1;
      id_q        <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      werr_q      <= 1'b0;
      rd_done_q   <= 1'b0;
      p_q         <= 1'b0;
      p_last_q    <= 1'b0;
      o_valid_q   <= 1'b0;
      o_last_q    <= 1'b0;
      o_data_q    <= '0;
      o_resp_q    <= '0;
      s_valid_q   <= 1'b0;
      s_last_q    <= 1'b0;
      s_data_q    <= '0;
      s_resp_q    <= '0;
    end else begin
      if (take_aw && arvalid)      fav_write_q <= 1'b0;
      else if (take_ar && awvalid) fav_write_q <= 1'b1;

      if (take_aw) begin
        id_q    <= awid;
        idx_q   <= aw_idx;
        len_q   <= awlen;
        burst_q <= awburst;
        cnt_q   <= 8'd0;
        werr_q  <= awburst[1];
      end else if (take_ar) begin
        // The first beat is read in the accept cycle, so the index already points at beat 1.
        id_q      <= arid;
        idx_q     <= ar_idx + {{(IDX_W-1){1'b0}}, (arburst == 2'b01)};
        len_q     <= arlen;
        burst_q   <= arburst;
        cnt_q     <= 8'd1;
        rd_done_q <= (arlen == 8'd0);
      end else begin
        if (w_beat) begin
          cnt_q <= cnt_q + 8'd1;
          if (burst_q == 2'b01) idx_q <= idx_q + 1'b1;
          if (wlast != (cnt_q == len_q)) werr_q <= 1'b1;
        end
        if (issue) begin
          cnt_q <= cnt_q + 8'd1;
          if (burst_q == 2'b01) idx_q <= idx_q + 1'b1;
          if (issue_last) rd_done_q <= 1'b1;
        end
      end

      p_q      <= issue;
      p_last_q <= issue_last;

      if (o_free) begin
        if (s_valid_q) begin
          o_valid_q <= 1'b1;
          o_data_q  <= s_data_q;
          o_resp_q  <= s_resp_q;
          o_last_q  <= s_last_q;
          s_valid_q <= p_q;
          s_data_q  <= in_data;
          s_resp_q  <= in_resp;
          s_last_q  <= p_last_q;
        end else begin
          o_valid_q <= p_q;
          if (p_q) begin
            o_data_q <= in_data;
            o_resp_q <= in_resp;
            o_last_q <= p_last_q;
          end
        end
      end else if (p_q) begin
        s_valid_q <= 1'b1;
        s_data_q  <= in_data;
        s_resp_q  <= in_resp;
        s_last_q  <= p_last_q;
      end
    end
  end

  // Storage and read register are never reset; WRAP/reserved writes leave memory untouched.
  always_ff @(posedge clk) begin
    if (w_beat && !burst_q[1]) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (issue) mem_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axi_sram_controller.sv
// Randomised bench for axi_sram_controller: drivers feed a word-array reference model,
// a negedge monitor pops expected B/R responses from queues and compares.
module tb_axi_sram_controller;
  localparam int DEPTH = 4096;
  localparam int ID_W  = 4;
  localparam int TMO   = 2000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ID_W-1:0] awid = '0, arid = '0;
  logic [31:0]     awaddr = '0, araddr = '0, wdata = '0;
  logic [7:0]      awlen = '0, arlen = '0;
  logic [1:0]      awburst = '0, arburst = '0;
  logic            awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [3:0]      wstrb = '0;
  logic            bready = 1'b0, rready = 1'b0;
  logic            awready, arready, wready, bvalid, rvalid, rlast;
  logic [ID_W-1:0] bid, rid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;

  axi_sram_controller #(.DEPTH_WORDS(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [ID_W+1:0]  b_exp_q[$];
  logic [ID_W+34:0] r_exp_q[$];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];
  bit          order_q[$];
  int          ar_cyc = 0;
  bit          lat_pending = 0;
  int          rr_mode = 0, rr_pat = 0;
  bit          stall = 0;
  logic [ID_W+35:0] stall_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within %0d cycles", name, TMO);
    report();
  endtask

  function automatic void model_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                                      input logic [7:0] len, input logic [1:0] burst);
    int idx = int'(addr >> 2) % DEPTH;
    bit err = burst[1];
    for (int k = 0; k <= int'(len); k++) begin
      if (wl[k] != (k == int'(len))) err = 1;
      if (!burst[1])
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) ref_mem[idx][8*b +: 8] = wd[k][8*b +: 8];
      if (burst == 2'b01) idx = (idx + 1) % DEPTH;
    end
    b_exp_q.push_back({id, err, 1'b0});
  endfunction

  function automatic void model_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                                     input logic [7:0] len, input logic [1:0] burst);
    int idx = int'(addr >> 2) % DEPTH;
    for (int k = 0; k <= int'(len); k++) begin
      r_exp_q.push_back({id, (burst[1] ? 32'd0 : ref_mem[idx]), (burst[1] ? 2'b10 : 2'b00),
                         (k == int'(len))});
      if (burst == 2'b01) idx = (idx + 1) % DEPTH;
    end
  endfunction

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready) begin
      if (++n > TMO) timeout("aw_accept");
      @(negedge clk);
    end
    model_write(id, addr, len, burst);
    order_q.push_back(1'b1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      wdata = wd[k]; wstrb = ws[k]; wlast = wl[k]; wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready) begin
        if (++n > TMO) timeout("w_accept");
        @(negedge clk);
      end
      @(posedge clk); #1 wvalid = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!(bvalid && bready)) begin
      if (++n > TMO) timeout("b_handshake");
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, output int wait_n);
    int n;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready) begin
      if (++n > TMO) timeout("ar_accept");
      @(negedge clk);
    end
    wait_n = n;
    model_read(id, addr, len, burst);
    order_q.push_back(1'b0);
    ar_cyc = cyc;
    lat_pending = 1;
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(rvalid && rready && rlast)) begin
      if (++n > TMO) timeout("r_last");
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  // Response-side back-pressure: 0 random, 1 pattern 1,0,0, 2 held low, 3 held high.
  always begin
    @(posedge clk); #1;
    case (rr_mode)
      0: rready = ($urandom_range(0, 3) != 0);
      1: begin rready = (rr_pat == 0); rr_pat = (rr_pat + 1) % 3; end
      2: rready = 1'b0;
      default: rready = 1'b1;
    endcase
    bready = ($urandom_range(0, 1) == 1);
  end

  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
    end else begin
      if (bvalid && bready) begin
        if (b_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected: got %h with nothing expected", {bid, bresp});
        end else check("bresp", 64'({bid, bresp}), 64'(b_exp_q.pop_front()));
      end
      if (rvalid && lat_pending) begin
        check("r_latency", 64'(cyc - ar_cyc), 64'd2);
        lat_pending = 0;
      end
      if (stall) check("r_stable", 64'({rvalid, rid, rdata, rresp, rlast}), 64'(stall_val));
      if (rvalid && rready) begin
        if (r_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_unexpected: got %h with nothing expected", {rid, rdata, rresp, rlast});
        end else check("rbeat", 64'({rid, rdata, rresp, rlast}), 64'(r_exp_q.pop_front()));
      end
      stall = rvalid && !rready;
      stall_val = {1'b1, rid, rdata, rresp, rlast};
    end
  end

  initial begin
    int n;
    logic [5:0] order_bits;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({awready, arready, wready, bvalid, rvalid, bid, bresp, rid, rdata, rresp, rlast}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single write then read.
    rr_mode = 3;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(4'd3, 32'h0000_0010, 8'd0, 2'b01);
    do_read(4'd5, 32'h0000_0010, 8'd0, 2'b01, n);

    // INCR burst, read back under a 1,0,0 rready pattern.
    for (int k = 0; k < 4; k++) begin wd[k] = 32'h11 * (k + 1); ws[k] = 4'hF; wl[k] = (k == 3); end
    do_write(4'd1, 32'h0000_0100, 8'd3, 2'b01);
    rr_mode = 1; rr_pat = 0;
    do_read(4'd2, 32'h0000_0100, 8'd3, 2'b01, n);
    rr_mode = 0;

    // Byte strobes on a FIXED burst.
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(4'd4, 32'h0000_0020, 8'd0, 2'b01);
    wd[0] = 32'h000000AA; ws[0] = 4'b0001; wl[0] = 1'b0;
    wd[1] = 32'hBB000000; ws[1] = 4'b1000; wl[1] = 1'b1;
    do_write(4'd4, 32'h0000_0020, 8'd1, 2'b00);
    do_read(4'd6, 32'h0000_0020, 8'd0, 2'b01, n);

    // Arbitration right after reset with both channels always pending.
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    order_q.delete();
    wd[0] = 32'h5A5A0001; ws[0] = 4'hF; wl[0] = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) do_write(4'(i), 32'h0000_0200 + 32'(4 * i), 8'd0, 2'b01);
      end
      begin
        int m;
        for (int i = 0; i < 3; i++) do_read(4'(8 + i), 32'h0000_0100 + 32'(4 * i), 8'd0, 2'b01, m);
      end
    join
    for (int i = 0; i < 6; i++) order_bits[5 - i] = (i < order_q.size()) ? order_q[i] : 1'b0;
    check("arb_order", 64'(order_bits), 64'b101010);

    // WRAP burst write leaves memory alone; early wlast still writes both beats.
    wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 1'b0; wl[1] = 1'b1;
    do_write(4'd7, 32'h0000_0010, 8'd1, 2'b10);
    do_read(4'd7, 32'h0000_0010, 8'd0, 2'b01, n);
    do_read(4'd7, 32'h0000_0010, 8'd1, 2'b10, n);
    wl[0] = 1'b1;
    do_write(4'd9, 32'h0000_0300, 8'd1, 2'b01);
    do_read(4'd9, 32'h0000_0300, 8'd1, 2'b01, n);

    // Index wrap at the top of memory.
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; wl[0] = 1'b0; wl[1] = 1'b1;
    do_write(4'd2, 32'h0000_3FFC, 8'd1, 2'b01);
    do_read(4'd3, 32'h0000_3FFC, 8'd1, 2'b01, n);

    // Reset in the middle of a stalled read burst.
    rr_mode = 2;
    arid = 4'd1; araddr = 32'h0000_0100; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready) begin
      if (++n > TMO) timeout("ar_accept_abort");
      @(negedge clk);
    end
    ar_cyc = cyc; lat_pending = 1;
    @(posedge clk); #1 arvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_rvalid_low", 64'(rvalid), 64'd0);
    @(posedge clk); #1 rst = 1'b0; rr_mode = 0;
    @(negedge clk);
    check("post_rst_rvalid_low", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    do_read(4'd4, 32'h0000_0010, 8'd0, 2'b01, n);
    check("idle_after_rst", 64'(n), 64'd0);

    // Random phase over a pre-filled low region and the top of memory.
    for (int k = 0; k < 64; k++) begin wd[k] = $urandom; ws[k] = 4'hF; wl[k] = (k == 63); end
    do_write(4'd0, 32'h0000_0000, 8'd63, 2'b01);
    for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'hF; wl[k] = (k == 7); end
    do_write(4'd0, 32'h0000_3FE0, 8'd7, 2'b01);
    for (int t = 0; t < 40; t++) begin
      int sel;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [31:0] addr;
      int idx;
      len = 8'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      burst = (sel < 5) ? 2'b01 : (sel < 8) ? 2'b00 : (sel == 8) ? 2'b10 : 2'b11;
      idx = ($urandom_range(0, 3) == 0) ? 4088 + $urandom_range(0, 7) : $urandom_range(0, 55);
      addr = {14'($urandom), 12'(idx), 2'($urandom)} | (32'($urandom_range(0, 15)) << 28);
      rr_mode = 0;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= int'(len); k++) begin
          wd[k] = $urandom;
          ws[k] = 4'($urandom_range(0, 15));
          wl[k] = (k == int'(len)) ^ ($urandom_range(0, 9) == 0);
        end
        do_write(4'($urandom), addr, len, burst);
      end else begin
        do_read(4'($urandom), addr, len, burst, n);
      end
    end

    n = 0;
    while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && n < TMO) begin
      @(posedge clk);
      n++;
    end
    check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_exp_q.size()), 64'd0);
    report();
  end

endmodule
